// File: rtl/snake_head_if.sv
// snake_head_if: control inputs and head position outputs of snake_head_ctrl
interface snake_head_if;
  logic        start;
  logic        dir_valid;
  logic [1:0]  dir_req;
  logic [9:0]  grid_size;
  logic [6:0]  head_col;
  logic [5:0]  head_row;
  logic [10:0] head_x;
  logic [10:0] head_y;
  logic        move_strobe;
  logic        game_over;
  logic        running;
  modport master (
    output start, dir_valid, dir_req, grid_size,
    input  head_col, head_row, head_x, head_y, move_strobe, game_over, running
  );
  modport slave (
    input  start, dir_valid, dir_req, grid_size,
    output head_col, head_row, head_x, head_y, move_strobe, game_over, running
  );
endinterface

// File: rtl/snake_head_ctrl.sv
// snake_head_ctrl: snake head movement FSM with wall collision and pixel conversion
module snake_head_ctrl #(
  parameter int TICK_DIV  = 6_500_000,
  parameter int GRID_COLS = 64,
  parameter int GRID_ROWS = 48,
  parameter int START_COL = 32,
  parameter int START_ROW = 24
) (
  input logic clk,
  input logic reset,
  snake_head_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
  localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);
  localparam logic [6:0]  COL_LAST  = 7'(GRID_COLS - 1);
  localparam logic [5:0]  ROW_LAST  = 6'(GRID_ROWS - 1);
  localparam logic [6:0]  COL_INIT  = 7'(START_COL);
  localparam logic [5:0]  ROW_INIT  = 6'(START_ROW);
  state_t state, state_nx;
  logic [6:0]  col, col_nx;
  logic [5:0]  row, row_nx;
  logic [1:0]  cur_dir, cur_nx, pend_dir, pend_nx;
  logic [23:0] tick, tick_nx;
  logic        mv, mv_nx, step, hit;
  logic [10:0] head_x, head_y;
  logic        move_strobe;
  assign step = state == RUN && tick == TICK_LAST;
  assign hit  = pend_dir == 2'd0 ? row == 6'd0 :
                pend_dir == 2'd1 ? col == COL_LAST :
                pend_dir == 2'd2 ? row == ROW_LAST : col == 7'd0;
  always_comb begin
    state_nx = state;
    col_nx   = col;
    row_nx   = row;
    cur_nx   = cur_dir;
    pend_nx  = pend_dir;
    tick_nx  = '0;
    mv_nx    = 1'b0;
    if (bus.start) begin
      state_nx = RUN;
      col_nx   = COL_INIT;
      row_nx   = ROW_INIT;
      cur_nx   = 2'd1;
      pend_nx  = 2'd1;
    end else if (state == RUN) begin
      tick_nx = step ? '0 : tick + 24'd1;
      // reversal is judged against the committed direction, so last accepted request wins
      if (bus.dir_valid && bus.dir_req != (cur_dir ^ 2'd2)) pend_nx = bus.dir_req;
      if (step && hit) state_nx = DEAD;
      else if (step) begin
        cur_nx = pend_dir;
        mv_nx  = 1'b1;
        col_nx = pend_dir == 2'd1 ? col + 7'd1 : pend_dir == 2'd3 ? col - 7'd1 : col;
        row_nx = pend_dir == 2'd2 ? row + 6'd1 : pend_dir == 2'd0 ? row - 6'd1 : row;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      col         <= COL_INIT;
      row         <= ROW_INIT;
      cur_dir     <= 2'd1;
      pend_dir    <= 2'd1;
      tick        <= '0;
      mv          <= 1'b0;
      head_x      <= '0;
      head_y      <= '0;
      move_strobe <= 1'b0;
    end else begin
      state       <= state_nx;
      col         <= col_nx;
      row         <= row_nx;
      cur_dir     <= cur_nx;
      pend_dir    <= pend_nx;
      tick        <= tick_nx;
      mv          <= mv_nx;
      head_x      <= {4'd0, col} * {1'b0, bus.grid_size};
      head_y      <= {5'd0, row} * {1'b0, bus.grid_size};
      move_strobe <= mv;
    end
  end
  assign bus.head_col    = col;
  assign bus.head_row    = row;
  assign bus.head_x      = head_x;
  assign bus.head_y      = head_y;
  assign bus.move_strobe = move_strobe;
  assign bus.game_over   = state == DEAD;
  assign bus.running     = state == RUN;
endmodule
